// File: rtl/stream_demux_buffered_if.sv
// Handshake bundle for stream_demux_buffered: one val/rdy input stream fanned out
// to noutputs val/rdy output streams, plus the discard counter.
interface stream_demux_buffered_if #(
  parameter int nbits    = 32,
  parameter int noutputs = 4,
  parameter int SELW     = $clog2(noutputs)
);
  logic [nbits-1:0]    recv_msg;
  logic [SELW-1:0]     recv_sel;
  logic                recv_bcast;
  logic                recv_val;
  logic                recv_rdy;
  logic [nbits-1:0]    send_msg [0:noutputs-1];
  logic [noutputs-1:0] send_val;
  logic [noutputs-1:0] send_rdy;
  logic [15:0]         drop_count;

  modport master (
    output recv_msg, recv_sel, recv_bcast, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val, drop_count
  );

  modport slave (
    input  recv_msg, recv_sel, recv_bcast, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val, drop_count
  );
endinterface

// File: rtl/stream_demux_buffered.sv
// Buffered val/rdy demux: each message goes to one output FIFO (or all of them on
// broadcast); out-of-range selectors are accepted, discarded and counted.
module stream_demux_buffered #(
  parameter int nbits    = 32,
  parameter int noutputs = 4,
  parameter int depth    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  stream_demux_buffered_if.slave s
);
  localparam int SELW = $clog2(noutputs);
  localparam int PW   = $clog2(depth);
  localparam int CW   = PW + 1;
  localparam int NSEL = 1 << SELW;

  logic [noutputs-1:0] full;
  logic [noutputs-1:0] enq;
  logic [noutputs-1:0] deq;
  logic [noutputs-1:0] val;
  logic [NSEL-1:0]     full_ext;
  logic                in_range;
  logic                is_bcast;
  logic                is_drop;
  logic                rdy;
  logic                accept;
  logic [15:0]         drop_count_reg;

  assign is_bcast = s.recv_bcast;

  generate
    if (NSEL == noutputs) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = ({1'b0, s.recv_sel} < (SELW + 1)'(noutputs));
    end
  endgenerate

  assign is_drop = !is_bcast && !in_range;

  // Unused selector codes read as full; they are never consulted since they drop.
  genvar gi;
  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_full_ext
      if (gi < noutputs) begin : g_real
        assign full_ext[gi] = full[gi];
      end else begin : g_pad
        assign full_ext[gi] = 1'b1;
      end
    end
  endgenerate

  // Ready looks only at FIFO occupancy, never at send_rdy or recv_val.
  always_comb begin
    rdy = 1'b1;
    if (is_bcast) begin
      rdy = ~|full;
    end else if (in_range) begin
      rdy = ~full_ext[s.recv_sel];
    end
  end

  assign s.recv_rdy = rdy;
  assign accept     = s.recv_val && rdy;

  generate
    for (gi = 0; gi < noutputs; gi++) begin : g_fifo
      logic [nbits-1:0] mem [depth];
      logic [PW-1:0]    rd_ptr_reg;
      logic [PW-1:0]    wr_ptr_reg;
      logic [CW-1:0]    count_reg;

      assign full[gi] = (count_reg == CW'(depth));
      assign val[gi]  = (count_reg != '0);
      assign enq[gi]  = accept && (is_bcast || (in_range && (s.recv_sel == SELW'(gi))));
      assign deq[gi]  = val[gi] && s.send_rdy[gi];

      assign s.send_val[gi] = val[gi];
      assign s.send_msg[gi] = val[gi] ? mem[rd_ptr_reg] : '0;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (enq[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (deq[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          case ({enq[gi], deq[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      // Storage carries no reset; the head is masked by val until written.
      always_ff @(posedge clk) begin
        if (enq[gi]) begin
          mem[wr_ptr_reg] <= s.recv_msg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_reg <= '0;
    end else if (accept && is_drop && (drop_count_reg != 16'hFFFF)) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign s.drop_count = drop_count_reg;
endmodule

// File: tb/tb_stream_demux_buffered.sv
// Scoreboard bench: instance A (4 outputs, depth 2) runs directed scenarios,
// instance B (3 outputs, depth 4) runs random traffic and drop saturation.
module tb_stream_demux_buffered;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_demux_buffered_if #(.nbits(32), .noutputs(4)) if_a ();
  stream_demux_buffered_if #(.nbits(16), .noutputs(3)) if_b ();

  stream_demux_buffered #(.nbits(32), .noutputs(4), .depth(2)) dut_a (
    .clk(clk), .reset_n(rst_a), .s(if_a)
  );
  stream_demux_buffered #(.nbits(16), .noutputs(3), .depth(4)) dut_b (
    .clk(clk), .reset_n(rst_b), .s(if_b)
  );

  // Reference model: per-output queues of in-flight messages and an expected drop count.
  logic [31:0] qa [4][$];
  logic [15:0] qb [3][$];
  logic [15:0] exp_drop_b = 16'd0;
  logic [3:0]  deq_a;
  logic [2:0]  deq_b;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic rdy_a_model();
    if (if_a.recv_bcast) begin
      for (int i = 0; i < 4; i++) if (qa[i].size() >= 2) return 1'b0;
      return 1'b1;
    end
    return qa[if_a.recv_sel].size() < 2;
  endfunction

  function automatic logic rdy_b_model();
    if (if_b.recv_bcast) begin
      for (int i = 0; i < 3; i++) if (qb[i].size() >= 4) return 1'b0;
      return 1'b1;
    end
    if (if_b.recv_sel >= 2'd3) return 1'b1;
    return qb[if_b.recv_sel].size() < 4;
  endfunction

  // Monitors: compare at the falling edge, retire dequeued entries at the rising edge.
  always @(negedge clk) begin
    deq_a = '0;
    if (rst_a) begin
      for (int i = 0; i < 4; i++) begin
        chk("a_send_val", {31'd0, if_a.send_val[i]}, {31'd0, qa[i].size() != 0});
        chk("a_send_msg", if_a.send_msg[i], (qa[i].size() != 0) ? qa[i][0] : 32'd0);
        if (if_a.send_val[i] && if_a.send_rdy[i] && qa[i].size() != 0) deq_a[i] = 1'b1;
      end
      chk("a_recv_rdy", {31'd0, if_a.recv_rdy}, {31'd0, rdy_a_model()});
      chk("a_drop_count", {16'd0, if_a.drop_count}, 32'd0);
    end
  end

  always @(negedge clk) begin
    deq_b = '0;
    if (rst_b) begin
      for (int i = 0; i < 3; i++) begin
        chk("b_send_val", {31'd0, if_b.send_val[i]}, {31'd0, qb[i].size() != 0});
        chk("b_send_msg", {16'd0, if_b.send_msg[i]}, {16'd0, (qb[i].size() != 0) ? qb[i][0] : 16'd0});
        if (if_b.send_val[i] && if_b.send_rdy[i] && qb[i].size() != 0) deq_b[i] = 1'b1;
      end
      chk("b_recv_rdy", {31'd0, if_b.recv_rdy}, {31'd0, rdy_b_model()});
      chk("b_drop_count", {16'd0, if_b.drop_count}, {16'd0, exp_drop_b});
    end
  end

  always @(posedge clk) begin
    if (!rst_a) begin
      for (int i = 0; i < 4; i++) qa[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) if (deq_a[i]) void'(qa[i].pop_front());
    end
    if (!rst_b) begin
      for (int i = 0; i < 3; i++) qb[i].delete();
      exp_drop_b = 16'd0;
    end else begin
      for (int i = 0; i < 3; i++) if (deq_b[i]) void'(qb[i].pop_front());
    end
  end

  // Stimulus: one cycle per call, entered and left 1 time unit after a rising edge.
  task automatic a_cycle(input logic v, input logic [1:0] sel, input logic bc,
                         input logic [31:0] m, input logic [3:0] rdy, output logic acc);
    if_a.recv_val = v; if_a.recv_sel = sel; if_a.recv_bcast = bc;
    if_a.recv_msg = m; if_a.send_rdy = rdy;
    @(negedge clk);
    acc = v && if_a.recv_rdy;
    @(posedge clk);
    if (acc) begin
      if (bc) for (int i = 0; i < 4; i++) qa[i].push_back(m);
      else qa[sel].push_back(m);
    end
    #1;
  endtask

  task automatic a_send(input logic [1:0] sel, input logic bc, input logic [31:0] m,
                        input logic [3:0] rdy, input string nm);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) a_cycle(1'b1, sel, bc, m, rdy, acc);
    chk(nm, {31'd0, acc}, 32'd1);
  endtask

  task automatic a_idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) a_cycle(1'b0, 2'd0, 1'b0, 32'd0, 4'hF, acc);
  endtask

  task automatic b_cycle(input logic v, input logic [1:0] sel, input logic bc,
                         input logic [15:0] m, input logic [2:0] rdy);
    logic acc;
    if_b.recv_val = v; if_b.recv_sel = sel; if_b.recv_bcast = bc;
    if_b.recv_msg = m; if_b.send_rdy = rdy;
    @(negedge clk);
    acc = v && if_b.recv_rdy;
    @(posedge clk);
    if (acc) begin
      if (bc) for (int i = 0; i < 3; i++) qb[i].push_back(m);
      else if (sel < 2'd3) qb[sel].push_back(m);
      else if (exp_drop_b != 16'hFFFF) exp_drop_b = exp_drop_b + 16'd1;
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    if_a.recv_val = 0; if_a.recv_sel = 0; if_a.recv_bcast = 0; if_a.recv_msg = 0; if_a.send_rdy = 0;
    if_b.recv_val = 0; if_b.recv_sel = 0; if_b.recv_bcast = 0; if_b.recv_msg = 0; if_b.send_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Reset mid-stream clears outputs immediately.
    a_cycle(1'b1, 2'd0, 1'b0, 32'h10, 4'h0, acc);
    a_cycle(1'b1, 2'd3, 1'b0, 32'h13, 4'h0, acc);
    a_cycle(1'b0, 2'd0, 1'b0, 32'h0, 4'h0, acc);
    chk("pre_reset_val", {28'd0, if_a.send_val}, 32'h9);
    #2 rst_a = 1'b0;
    #1;
    chk("reset_val", {28'd0, if_a.send_val}, 32'h0);
    for (int i = 0; i < 4; i++) chk("reset_msg", if_a.send_msg[i], 32'h0);
    @(posedge clk);
    #1 rst_a = 1'b1;

    // Basic unicast with one cycle of latency.
    a_cycle(1'b1, 2'd2, 1'b0, 32'hA5, 4'hF, acc);
    chk("uni_acc", {31'd0, acc}, 32'd1);
    chk("uni_val", {28'd0, if_a.send_val}, 32'h4);
    chk("uni_msg2", if_a.send_msg[2], 32'hA5);
    chk("uni_msg0", if_a.send_msg[0], 32'h0);
    a_idle(1);
    chk("uni_drained", {28'd0, if_a.send_val}, 32'h0);

    // Backpressure: FIFO[1] fills at two, no same-cycle credit when ready rises.
    a_cycle(1'b1, 2'd1, 1'b0, 32'h1, 4'b1101, acc); chk("bp_acc1", {31'd0, acc}, 32'd1);
    a_cycle(1'b1, 2'd1, 1'b0, 32'h2, 4'b1101, acc); chk("bp_acc2", {31'd0, acc}, 32'd1);
    a_cycle(1'b1, 2'd1, 1'b0, 32'h3, 4'b1101, acc); chk("bp_full", {31'd0, acc}, 32'd0);
    a_cycle(1'b1, 2'd1, 1'b0, 32'h3, 4'b1111, acc); chk("bp_no_credit", {31'd0, acc}, 32'd0);
    a_send(2'd1, 1'b0, 32'h3, 4'hF, "bp_acc3");
    a_idle(4);

    // Isolation: stalled full FIFO[1] does not block outputs 0 and 3.
    a_send(2'd1, 1'b0, 32'h11, 4'b1101, "iso_fill1");
    a_send(2'd1, 1'b0, 32'h12, 4'b1101, "iso_fill2");
    for (int k = 0; k < 8; k++) begin
      a_cycle(1'b1, (k % 2 == 1) ? 2'd3 : 2'd0, 1'b0, 32'h20 + k, 4'b1101, acc);
      chk("iso_acc", {31'd0, acc}, 32'd1);
    end
    a_idle(4);

    // Broadcast is all-or-none and waits for room in every FIFO.
    a_send(2'd2, 1'b0, 32'h31, 4'b1011, "bc_fill1");
    a_send(2'd2, 1'b0, 32'h32, 4'b1011, "bc_fill2");
    a_cycle(1'b1, 2'd0, 1'b1, 32'h77, 4'b1011, acc); chk("bc_blocked", {31'd0, acc}, 32'd0);
    a_cycle(1'b1, 2'd0, 1'b1, 32'h77, 4'b1111, acc); chk("bc_no_credit", {31'd0, acc}, 32'd0);
    a_cycle(1'b1, 2'd0, 1'b1, 32'h77, 4'b0000, acc); chk("bc_acc", {31'd0, acc}, 32'd1);
    chk("bc_val", {28'd0, if_a.send_val}, 32'hF);
    chk("bc_msg0", if_a.send_msg[0], 32'h77);
    chk("bc_msg1", if_a.send_msg[1], 32'h77);
    chk("bc_msg2", if_a.send_msg[2], 32'h32);
    chk("bc_msg3", if_a.send_msg[3], 32'h77);
    a_idle(4);

    // Out-of-range selector on the 3-output instance is accepted and counted.
    b_cycle(1'b1, 2'd3, 1'b0, 16'h55, 3'b111);
    chk("drop_one", {16'd0, if_b.drop_count}, 32'd1);
    chk("drop_no_val", {29'd0, if_b.send_val}, 32'd0);

    // Random traffic with concurrent enqueue/dequeue and pointer wrap.
    for (int k = 0; k < 10000; k++) begin
      b_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
              16'($urandom), 3'($urandom_range(0, 7)));
    end

    // Saturation of the drop counter.
    for (int k = 0; k < 65537; k++) begin
      b_cycle(1'b1, 2'd3, 1'b0, 16'($urandom), 3'($urandom_range(0, 7)));
    end
    chk("drop_saturate", {16'd0, if_b.drop_count}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
